// File: rtl/fp_pkg.sv
// Shared types and helpers for the feed-forward equaliser tap-window datapath.
package fp_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } tap_state_e;

  function automatic int calc_total_tap(input int pre_tap, input int main_tap, input int post_tap);
    return pre_tap + main_tap + post_tap;
  endfunction

endpackage

// File: rtl/tap_window_assemble.sv
// Combinational window builder: {next head, cur, prev tail} with pre-taps in the LSB lanes.
module tap_window_assemble
  import fp_pkg::*;
#(
  parameter int MAIN_TAP         = 28,
  parameter int PRE_TAP          = 28,
  parameter int POST_TAP         = 28,
  parameter int INPUT_DATA_WIDTH = 8
) (
  input  logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0]                                   prev_blk,
  input  logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0]                                   cur_blk,
  input  logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0]                                   next_blk,
  input  logic                                                                   next_zero,
  output logic [INPUT_DATA_WIDTH*calc_total_tap(PRE_TAP, MAIN_TAP, POST_TAP)-1:0] window
);

  localparam int W         = INPUT_DATA_WIDTH;
  localparam int TOTAL_TAP = calc_total_tap(PRE_TAP, MAIN_TAP, POST_TAP);

  // Only the newest PRE_TAP samples of prev and oldest POST_TAP of next are used.
  logic unused_bits;
  assign unused_bits = ^{prev_blk, next_blk, next_zero};

  generate
    if (PRE_TAP > 0) begin : g_pre
      assign window[W*PRE_TAP-1:0] = prev_blk[W*MAIN_TAP-1 -: W*PRE_TAP];
    end
    if (POST_TAP > 0) begin : g_post
      assign window[W*TOTAL_TAP-1 -: W*POST_TAP] = next_zero ? '0 : next_blk[W*POST_TAP-1:0];
    end
  endgenerate

  assign window[W*(PRE_TAP+MAIN_TAP)-1 -: W*MAIN_TAP] = cur_blk;

endmodule

// File: rtl/tap_window_buffer.sv
// Sample-window assembler with prev/cur/lookahead history, framing and back-pressure.
// Optional TAPWIN_STATS_EN adds win_count / stall_count statistics outputs.
module tap_window_buffer
  import fp_pkg::*;
#(
  parameter int MAIN_TAP         = 28,
  parameter int PRE_TAP          = 28,
  parameter int POST_TAP         = 28,
  parameter int INPUT_DATA_WIDTH = 8
) (
  input  logic                                                                   clk,
  input  logic                                                                   reset,
  input  logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0]                                   in_data,
  input  logic                                                                   in_valid,
  input  logic                                                                   in_last,
  output logic                                                                   in_ready,
  output logic [INPUT_DATA_WIDTH*calc_total_tap(PRE_TAP, MAIN_TAP, POST_TAP)-1:0] out_window,
  output logic                                                                   out_valid,
  output logic                                                                   out_last,
  input  logic                                                                   out_ready
`ifdef TAPWIN_STATS_EN
  ,
  output logic [15:0]                                                            win_count,
  output logic [15:0]                                                            stall_count
`endif
);

  localparam int TOTAL_TAP = calc_total_tap(PRE_TAP, MAIN_TAP, POST_TAP);
  localparam int BLK_W     = INPUT_DATA_WIDTH * MAIN_TAP;

  tap_state_e             state;
  logic [BLK_W-1:0]       blk_prev;
  logic [BLK_W-1:0]       blk_cur;
  logic [INPUT_DATA_WIDTH*TOTAL_TAP-1:0] win_next;
  logic                   slot_free;
  logic                   accept;
  logic                   load;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign load      = ((state == RUN) && accept) || ((state == TAIL) && slot_free);

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = slot_free;
      default: in_ready = 1'b0;
    endcase
  end

  // In TAIL the lookahead lanes are forced to zero since no next block exists.
  tap_window_assemble #(
    .MAIN_TAP        (MAIN_TAP),
    .PRE_TAP         (PRE_TAP),
    .POST_TAP        (POST_TAP),
    .INPUT_DATA_WIDTH(INPUT_DATA_WIDTH)
  ) u_assemble (
    .prev_blk (blk_prev),
    .cur_blk  (blk_cur),
    .next_blk (in_data),
    .next_zero(state == TAIL),
    .window   (win_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      blk_prev   <= '0;
      blk_cur    <= '0;
      out_window <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (load) begin
        out_window <= win_next;
        out_last   <= (state == TAIL);
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            blk_prev <= '0;
            blk_cur  <= in_data;
            state    <= in_last ? TAIL : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            blk_prev <= blk_cur;
            blk_cur  <= in_data;
            if (in_last) state <= TAIL;
          end
        end
        TAIL: begin
          if (slot_free) begin
            blk_prev <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TAPWIN_STATS_EN
  // win_count wraps naturally; stall_count sticks at its maximum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_count   <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid && out_ready) win_count <= win_count + 16'd1;
      if (out_valid && !out_ready && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tap_window_buffer.sv
// Directed self-checking bench for tap_window_buffer (MAIN=4, PRE=2, POST=2, 8-bit samples).
module tb_tap_window_buffer;
  import fp_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_window;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
`ifdef TAPWIN_STATS_EN
  logic [15:0] win_count;
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [64:0] got_q[$];

  tap_window_buffer #(
    .MAIN_TAP(4), .PRE_TAP(2), .POST_TAP(2), .INPUT_DATA_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_window(out_window), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef TAPWIN_STATS_EN
    , .win_count(win_count), .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every window consumed; inputs only change just after posedge, so negedge is stable.
  always @(negedge clk)
    if (reset && out_valid && out_ready) got_q.push_back({out_last, out_window});

  task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] blk4(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [64:0] win8(input logic lst, input logic [7:0] a, b, c, d, e, f, g, h);
    return {lst, h, g, f, e, d, c, b, a};
  endfunction

  // Offer one block and hold it until accepted; entered and left at posedge+1.
  task automatic applyStimulus(input logic [31:0] d, input logic lst);
    int cyc;
    cyc = 0;
    in_data  = d;
    in_last  = lst;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) checkOutput("accept_timeout", 65'(cyc), 65'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitWindows(input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("window_count", 65'(got_q.size()), 65'(n));
  endtask

  task automatic checkQueue(input string tag, input int idx, input logic [64:0] expected);
    if (idx < got_q.size()) checkOutput(tag, got_q[idx], expected);
    else checkOutput(tag, 65'h1_FFFF_FFFF_FFFF_FFFF, expected);
  endtask

  initial begin
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 65'(out_valid), 65'd0);
    checkOutput("rst_out_last", 65'(out_last), 65'd0);
    checkOutput("rst_out_window", 65'(out_window), 65'd0);
    checkOutput("rst_in_ready", 65'(in_ready), 65'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two-block frame
    applyStimulus(blk4(1, 2, 3, 4), 1'b0);
    applyStimulus(blk4(5, 6, 7, 8), 1'b1);
    waitWindows(2);
    checkQueue("ab_w0", 0, win8(0, 0, 0, 1, 2, 3, 4, 5, 6));
    checkQueue("ab_w1", 1, win8(1, 3, 4, 5, 6, 7, 8, 0, 0));
    got_q.delete();

    // Single-block frame padded on both sides
    applyStimulus(blk4(9, 9, 9, 9), 1'b1);
    waitWindows(1);
    checkQueue("single_w0", 0, win8(1, 0, 0, 9, 9, 9, 9, 0, 0));
    checkOutput("single_idle", 65'(in_ready), 65'd1);
    got_q.delete();

    // Back-pressure: output fills, input stalls, window held steady
    out_ready = 1'b0;
    applyStimulus(blk4(10, 11, 12, 13), 1'b0);
    applyStimulus(blk4(14, 15, 16, 17), 1'b0);
    in_data  = blk4(18, 19, 20, 21);
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 65'(in_ready), 65'd0);
      checkOutput("bp_out_valid", 65'(out_valid), 65'd1);
      checkOutput("bp_hold", {out_last, out_window}, win8(0, 0, 0, 10, 11, 12, 13, 14, 15));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(blk4(18, 19, 20, 21), 1'b1);
    waitWindows(3);
    checkQueue("bp_w0", 0, win8(0, 0, 0, 10, 11, 12, 13, 14, 15));
    checkQueue("bp_w1", 1, win8(0, 12, 13, 14, 15, 16, 17, 18, 19));
    checkQueue("bp_w2", 2, win8(1, 16, 17, 18, 19, 20, 21, 0, 0));
    got_q.delete();

    // Back-to-back frames: no leakage into the second frame's pre-taps
    applyStimulus(blk4(31, 32, 33, 34), 1'b0);
    applyStimulus(blk4(35, 36, 37, 38), 1'b1);
    applyStimulus(blk4(41, 42, 43, 44), 1'b0);
    applyStimulus(blk4(45, 46, 47, 48), 1'b1);
    waitWindows(4);
    checkQueue("b2b_w0", 0, win8(0, 0, 0, 31, 32, 33, 34, 35, 36));
    checkQueue("b2b_w1", 1, win8(1, 33, 34, 35, 36, 37, 38, 0, 0));
    checkQueue("b2b_w2", 2, win8(0, 0, 0, 41, 42, 43, 44, 45, 46));
    checkQueue("b2b_w3", 3, win8(1, 43, 44, 45, 46, 47, 48, 0, 0));
    got_q.delete();

    // Reset mid-frame with a window pending
    out_ready = 1'b0;
    applyStimulus(blk4(50, 51, 52, 53), 1'b0);
    applyStimulus(blk4(54, 55, 56, 57), 1'b0);
    checkOutput("pre_rst_valid", 65'(out_valid), 65'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 65'(out_valid), 65'd0);
    checkOutput("midrst_in_ready", 65'(in_ready), 65'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    applyStimulus(blk4(60, 61, 62, 63), 1'b0);
    applyStimulus(blk4(64, 65, 66, 67), 1'b1);
    waitWindows(2);
    checkQueue("rst_w0", 0, win8(0, 0, 0, 60, 61, 62, 63, 64, 65));
    checkQueue("rst_w1", 1, win8(1, 62, 63, 64, 65, 66, 67, 0, 0));
    got_q.delete();

`ifdef TAPWIN_STATS_EN
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checkOutput("stats_rst_win", 65'(win_count), 65'd0);
    checkOutput("stats_rst_stall", 65'(stall_count), 65'd0);
    out_ready = 1'b0;
    applyStimulus(blk4(70, 71, 72, 73), 1'b0);
    applyStimulus(blk4(74, 75, 76, 77), 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    applyStimulus(blk4(78, 79, 80, 81), 1'b1);
    waitWindows(3);
    checkOutput("stats_win_count", 65'(win_count), 65'd3);
    checkOutput("stats_stall_count", 65'(stall_count), 65'd4);
    got_q.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
